fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the fetch program counter and issues word requests to instruction memory, with at most one request outstanding. It captures the returned instruction into a one-entry output register and hands it to decode with a valid/ready handshake. It accepts branch/jump redirects from execute and squashes any stale request, response or buffered instruction.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight, and buffers one instruction for decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects deliver a flagged NOP instead of fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misaligned
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends combinationally on ready, and payload is held while valid && !ready.

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] req_pc, req_pc_n;
    logic        drop, drop_n;
    logic        started;
    logic        valid_n, mis_n;
    logic [31:0] pc_n, instr_n;
    logic [31:0] redirect_target;
    logic        misaligned_redirect;
    logic        req_fire;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target     = redirect_pc;
    assign misaligned_redirect = (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign misaligned_redirect = 1'b0;
`endif

    // started is a register so the request stays low throughout reset without a path from rst.
    assign imem_req_valid = started && (state == REQ);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= REQ;
            fetch_pc      <= RESET_PC;
            req_pc        <= 32'h0;
            drop          <= 1'b0;
            started       <= 1'b0;
            if_valid      <= 1'b0;
            if_pc         <= 32'h0;
            if_instr      <= 32'h0;
            if_misaligned <= 1'b0;
        end else begin
            state         <= state_n;
            fetch_pc      <= fetch_pc_n;
            req_pc        <= req_pc_n;
            drop          <= drop_n;
            started       <= 1'b1;
            if_valid      <= valid_n;
            if_pc         <= pc_n;
            if_instr      <= instr_n;
            if_misaligned <= mis_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        drop_n     = drop;
        valid_n    = if_valid;
        pc_n       = if_pc;
        instr_n    = if_instr;
        mis_n      = if_misaligned;

        case (state)
            REQ: begin
                if (req_fire) begin
                    req_pc_n   = fetch_pc;
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        valid_n = 1'b1;
                        pc_n    = req_pc;
                        instr_n = imem_rsp_data;
                        mis_n   = 1'b0;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (if_valid && if_ready) begin
                    valid_n = 1'b0;
                    // A delivered misalignment trap parks here until execute redirects.
                    if (!if_misaligned) state_n = REQ;
                end
            end
            default: state_n = REQ;
        endcase

        if (redirect_valid) begin
            fetch_pc_n = redirect_target;
            valid_n    = 1'b0;
            pc_n       = if_pc;
            instr_n    = if_instr;
            mis_n      = 1'b0;
            case (state)
                REQ: begin
                    // An accepted request cannot be recalled; its response is dropped instead.
                    state_n = req_fire ? WAIT : REQ;
                    drop_n  = req_fire;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        drop_n  = 1'b1;
                        state_n = WAIT;
                    end
                end
                default: state_n = REQ;
            endcase
            if (misaligned_redirect) begin
                valid_n = 1'b1;
                pc_n    = redirect_pc;
                instr_n = 32'h0000_0013;
                mis_n   = 1'b1;
                state_n = HOLD;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural 1-cycle imem, transfer scoreboard, step-by-step checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [63:0] exp_q[$];
    logic [31:0] acc_addr_q[$];
    int          acc_cyc_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misaligned  (if_misaligned)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // imem model: answers 0xA0000000|addr in the cycle after acceptance
    always @(posedge clk) begin
        logic        acc;
        logic [31:0] addr;
        acc  = imem_req_valid && imem_req_ready;
        addr = imem_req_addr;
        if (acc) begin
            acc_addr_q.push_back(addr);
            acc_cyc_q.push_back(cyc);
        end
        cyc++;
        #1;
        imem_rsp_valid = acc;
        imem_rsp_data  = acc ? (32'hA000_0000 | addr) : 32'h0;
    end

    // scoreboard: every decode transfer must match the next expected {pc, instr}
    always @(posedge clk) begin
        logic [63:0] e;
        if (!rst && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer_pc", if_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", if_pc, e[63:32]);
                check("xfer_instr", if_instr, e[31:0]);
            end
        end
    end

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!if_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!imem_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_rsp_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_mis", {31'd0, if_misaligned}, 32'd0);
        rst = 1'b0;

        // sequential fetch
        @(negedge clk);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        exp_q.push_back({32'h0, 32'hA000_0000});
        exp_q.push_back({32'h4, 32'hA000_0004});
        wait_out("out0");
        check("out0_pc", if_pc, 32'h0);
        check("out0_instr", if_instr, 32'hA000_0000);

        // decode stalls on the second instruction
        @(negedge clk);
        if_ready = 1'b0;
        wait_out("out4");
        check("out4_pc", if_pc, 32'h4);
        check("out4_instr", if_instr, 32'hA000_0004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h4);
            check("stall_instr", if_instr, 32'hA000_0004);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        check("acc0_addr", acc_addr_q[0], 32'h0);
        check("acc1_addr", acc_addr_q[1], 32'h4);
        check("acc_spacing", acc_cyc_q[1] - acc_cyc_q[0], 32'd3);
        if_ready = 1'b1;
        @(negedge clk);
        check("unstall_if_valid", {31'd0, if_valid}, 32'd0);
        check("req8_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req8_addr", imem_req_addr, 32'h8);

        // redirect coincident with acceptance of 0x8
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("drop_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("req100_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req100_addr", imem_req_addr, 32'h100);
        check("req100_if_valid", {31'd0, if_valid}, 32'd0);
        exp_q.push_back({32'h100, 32'hA000_0100});
        wait_out("out100");
        check("out100_pc", if_pc, 32'h100);

        // redirect in WAIT with the response arriving the same cycle
        wait_rsp("rsp104");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("req200_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req200_addr", imem_req_addr, 32'h200);
        check("req200_if_valid", {31'd0, if_valid}, 32'd0);
        exp_q.push_back({32'h200, 32'hA000_0200});
        wait_out("out200");
        check("out200_pc", if_pc, 32'h200);

        // unaccepted request retargeted, then PC wrap at the top of memory
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("req204_addr", imem_req_addr, 32'h204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("reqtop_valid", {31'd0, imem_req_valid}, 32'd1);
        check("reqtop_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        exp_q.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC});
        exp_q.push_back({32'h0, 32'hA000_0000});
        wait_out("outtop");
        check("outtop_pc", if_pc, 32'hFFFF_FFFC);
        wait_out("outwrap");
        check("outwrap_pc", if_pc, 32'h0);
        check("wrap_acc_addr", acc_addr_q[$], 32'h0);

        // misaligned redirect target
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("req4_addr", imem_req_addr, 32'h4);
`ifdef FETCH_ALIGN_CHECK_EN
        exp_q.push_back({32'h102, 32'h0000_0013});
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("mis_if_valid", {31'd0, if_valid}, 32'd1);
        check("mis_if_pc", if_pc, 32'h102);
        check("mis_if_instr", if_instr, 32'h0000_0013);
        check("mis_flag", {31'd0, if_misaligned}, 32'd1);
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("mis_parked_valid", {31'd0, if_valid}, 32'd0);
        check("mis_parked_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("mis_parked_req2", {31'd0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("req300_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req300_addr", imem_req_addr, 32'h300);
        exp_q.push_back({32'h300, 32'hA000_0300});
        wait_out("out300");
        check("out300_pc", if_pc, 32'h300);
`else
        check("align_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("align_req_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;
        exp_q.push_back({32'h100, 32'hA000_0100});
        wait_out("outalign");
        check("outalign_pc", if_pc, 32'h100);
        check("outalign_mis", {31'd0, if_misaligned}, 32'd0);
`endif

        // reset while a response is in flight; the late response must be ignored
        wait_rsp("rsp_pre_reset");
        #2 rst = 1'b1;
        #2;
        check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_if_pc", if_pc, 32'h0);
        check("midrst_if_instr", if_instr, 32'h0);
        rst = 1'b0;
        exp_q.push_back({32'h0, 32'hA000_0000});
        wait_out("out_post_rst");
        check("post_rst_pc", if_pc, 32'h0);
        check("post_rst_instr", if_instr, 32'hA000_0000);
        check("post_rst_acc_addr", acc_addr_q[$], 32'h0);

        @(negedge clk);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
